// File: rtl/m707_tty_tx.sv
// Teletype transmitter: 1 start bit, 8 data bits LSB first, STOP_BITS stop bits.
// Raises a sticky done flag when the frame completes. Line idles at mark (1).
module m707_tty_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       load,
    input  logic       flag_clear,
    output logic       serial_out,
    output logic       busy,
    output logic       flag
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    idx, idx_n;
    logic          stop_cnt, stop_cnt_n;
    logic [7:0]    shift, shift_n;
    logic          serial_n, busy_n, flag_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            idx        <= '0;
            stop_cnt   <= 1'b0;
            shift      <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            flag       <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            idx        <= idx_n;
            stop_cnt   <= stop_cnt_n;
            shift      <= shift_n;
            serial_out <= serial_n;
            busy       <= busy_n;
            flag       <= flag_n;
        end
    end

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        idx_n      = idx;
        stop_cnt_n = stop_cnt;
        shift_n    = shift;
        serial_n   = serial_out;
        busy_n     = busy;
        flag_n     = flag & ~flag_clear;

        case (state)
            IDLE: begin
                serial_n = 1'b1;
                busy_n   = 1'b0;
                if (load) begin
                    shift_n  = data;
                    flag_n   = 1'b0;
                    state_n  = START;
                    timer_n  = BIT_LAST;
                    serial_n = 1'b0;
                    busy_n   = 1'b1;
                end
            end
            START: begin
                if (timer == '0) begin
                    state_n  = DATA;
                    timer_n  = BIT_LAST;
                    idx_n    = 3'd0;
                    serial_n = shift[0];
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_n = BIT_LAST;
                    if (idx == 3'd7) begin
                        state_n    = STOP;
                        stop_cnt_n = 1'b0;
                        serial_n   = 1'b1;
                    end else begin
                        // next bit to drive is the one about to land in bit 0
                        shift_n  = shift >> 1;
                        idx_n    = idx + 3'd1;
                        serial_n = shift[1];
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            STOP: begin
                if (timer == '0) begin
                    if (stop_cnt == STOP_LAST) begin
                        state_n  = IDLE;
                        busy_n   = 1'b0;
                        flag_n   = 1'b1;
                        serial_n = 1'b1;
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                        timer_n    = BIT_LAST;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: doc/m707_tty_tx.md
Name: m707_tty_tx

Overview:
- Teletype transmitter stage. Accepts an 8-bit character from the AC/IO path on a load strobe and serializes it as an asynchronous frame: 1 start, 8 data LSB-first, and STOP_BITS stop bits.
- Raises a done flag when the frame has been sent.
- serial_out is mark-high and feeds directly into a positive level driver input pair, which produces the external line level.

Parameters:
- CLKS_PER_BIT, 4, clock cycles per serial bit; must be >= 2.
- STOP_BITS, 2, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- data  input  8  character to send; sampled only on an accepted load.
- load  input  1  one-cycle strobe requesting transmission (TLS).
- flag_clear  input  1  one-cycle strobe clearing flag (TCF).
- serial_out  output  1  serial line, 1 = mark/idle, 0 = space.
- busy  output  1  high while a frame is in progress.
- flag  output  1  transmitter-done flag, sticky until cleared.

Behaviour:
- Reset: reset=1 at a rising edge forces the following, regardless of current state:
  - serial_out=1, busy=0, flag=0;
  - state=IDLE, bit timer=0, bit index=0, shift register=0.
  - Reset mid-frame aborts the frame immediately; no partial stop bits are sent.
- States: IDLE, START, DATA, STOP. All outputs are registered.
- Bit timer: width clog2(CLKS_PER_BIT). It loads CLKS_PER_BIT-1 on entry to each bit and decrements each cycle. The bit ends in the cycle the timer reads 0, so every bit lasts exactly CLKS_PER_BIT cycles.
- IDLE: serial_out=1, busy=0.
  - load=1 accepts the request: latch data into the shift register, clear flag, go to START.
  - Next cycle: serial_out=0, busy=1. Latency from load edge to start bit is 1 cycle.
- START: serial_out=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - serial_out = shift register bit 0.
  - At the end of each bit, shift right and increment the index.
  - After index 7 completes, go to STOP with stop counter 0.
- STOP: serial_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the end of the last stop bit, go to IDLE: busy=0 and flag=1 take effect in the same next cycle.
- Total frame: (9+STOP_BITS)*CLKS_PER_BIT cycles from the first start-bit cycle to busy falling.
- load while busy=1 is ignored: no data relatch, frame timing unaffected, flag unaffected.
  - This includes the final stop-bit cycle; busy is still 1 there.
- flag_clear=1 clears flag on the next edge in any state.
- flag_clear coinciding with the flag-set event: set wins, flag=1.
- load and flag_clear together in IDLE: load accepted, flag=0.
- data changes after an accepted load do not affect the frame in flight.
- Back-to-back frames: load in the first IDLE cycle after busy falls is accepted. The gap is 1 idle mark cycle.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=2 unless noted):
- Reset: hold reset 3 cycles, release -> serial_out=1, busy=0, flag=0; stays so with no load for 20 cycles.
- Single frame: load=1 with data=0x55 for one cycle -> serial_out sequence in 4-cycle bits is 0 (start), then 1,0,1,0,1,0,1,0, then 1,1 (stops).
  - busy high exactly 44 cycles.
  - flag=1 the cycle busy falls and remains 1.
- Ignored load: start a frame with 0x41; at cycle 10 assert load with data=0xFF -> transmitted bits still 1,0,0,0,0,0,1,0 (0x41 LSB-first) and frame length unchanged.
- Flag semantics:
  - flag_clear after the frame -> flag=0 next cycle.
  - flag_clear in the same cycle flag would set -> flag=1.
  - load+flag_clear in IDLE -> frame starts, flag=0.
- Mid-frame reset: reset during DATA bit 3 -> next cycle serial_out=1, busy=0, flag=0; a subsequent load of 0x00 produces a clean full frame.
- Parameter sweep: CLKS_PER_BIT=2, STOP_BITS=1, data=0x80 -> 20-cycle frame; the last data bit (bit 7) is 0 for bits 0..6 and 1 for bit 7, followed by one 2-cycle stop.
